// File: rtl/shift_add_multiplier_if.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier_if
//
// Purpose:
//   Groups the request/response signals of the shift-and-add multiplier core
//   into one bundle. The operand side (start, a, b) is driven by whoever owns
//   the operand registers. The result side (busy, done, product) is driven
//   by the multiplier core.
//
// Parameters:
//   WIDTH   operand width in bits; the product is 2*WIDTH bits.
//
// Signals:
//   start    request a multiply (acted on only while the core is idle)
//   a        multiplicand
//   b        multiplier
//   busy     core is iterating
//   done     one-cycle pulse, product is valid and freshly updated
//   product  registered double-width result
//
// Modports:
//   master   operand source: drives start/a/b, observes busy/done/product
//   slave    multiplier core: observes start/a/b, drives busy/done/product
// ---------------------------------------------------------------------------
interface shift_add_multiplier_if #(
    parameter int WIDTH = 8
) ();

    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output product
    );

endinterface

// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
//
// Purpose:
//   Sequential shift-and-add multiplier core. A start request in IDLE
//   captures both operands. The core then runs exactly WIDTH iterations, one
//   per clock. Each iteration conditionally adds the multiplicand into the
//   upper half of the accumulator and shifts the accumulator right. The
//   finished result is loaded into the product register, and done pulses for
//   one cycle. Intermediate accumulator values are never visible on product.
//
// Parameters:
//   WIDTH   operand width in bits (WIDTH >= 2); product is 2*WIDTH bits.
//
// Ports:
//   clk     system clock, all state changes on the rising edge
//   reset   synchronous active-high reset, priority over everything else
//   bus     shift_add_multiplier_if.slave
//             start   (in)  request a multiply, sampled only in IDLE
//             a       (in)  multiplicand
//             b       (in)  multiplier
//             busy    (out) high while iterating (state RUN)
//             done    (out) one-cycle pulse in state DONE
//             product (out) registered result, held until the next completion
//
// Optional feature:
//   MULT_SIGNED_EN  when defined, a and b are two's-complement. Their
//                   magnitudes are multiplied unsigned, and the result is
//                   negated on completion when the operand signs differ.
//                   When undefined, the core is purely unsigned and contains
//                   no sign logic.
//
// Timing:
//   Edge E0 accepts start. busy is high from after E0 through edge E_WIDTH.
//   done and the new product appear after E_WIDTH, and the core is back in
//   IDLE one cycle later. This gives one result every WIDTH+2 cycles.
// ---------------------------------------------------------------------------
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    shift_add_multiplier_if.slave bus
);

    // Counter must be able to hold the value WIDTH itself.
    localparam int                CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q,   state_d;
    logic [WIDTH-1:0]     mcand_q,   mcand_d;
    logic [WIDTH-1:0]     mplier_q,  mplier_d;
    logic [2*WIDTH-1:0]   acc_q,     acc_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    // Upper accumulator half plus carry, after the optional add.
    logic [WIDTH:0]       upper_sum;
    // Accumulator value after this iteration's add-and-shift.
    logic [2*WIDTH-1:0]   acc_shift;
    // Value that gets loaded into product on the last iteration.
    logic [2*WIDTH-1:0]   result;
    // Values captured into the operand copies when start is accepted.
    logic [WIDTH-1:0]     mcand_load;
    logic [WIDTH-1:0]     mplier_load;

`ifdef MULT_SIGNED_EN
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    logic sign_q, sign_d;

    // Magnitudes of the two's-complement operands. The most negative value
    // negates to itself, which read as unsigned is exactly 2^(WIDTH-1).
    assign mcand_load  = bus.a[WIDTH-1] ? (~bus.a + ONE_W) : bus.a;
    assign mplier_load = bus.b[WIDTH-1] ? (~bus.b + ONE_W) : bus.b;

    // The unsigned magnitude product never exceeds 2^(2*WIDTH-2), so the
    // negation below always fits in the double-width product.
    assign result = sign_q ? (~acc_shift + ONE_2W) : acc_shift;
`else
    assign mcand_load  = bus.a;
    assign mplier_load = bus.b;
    assign result      = acc_shift;
`endif

    // One datapath iteration. The add is done one bit wider than the
    // operand so the carry is kept. It then drops into the top bit on the
    // right shift, which is why the accumulator never overflows.
    always_comb begin
        upper_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        if (mplier_q[0]) begin
            upper_sum = upper_sum + {1'b0, mcand_q};
        end
    end

    assign acc_shift = {upper_sum, acc_q[WIDTH-1:1]};

    // Next-state and datapath control. Every register holds by default and
    // is changed only by the state that owns it. The product register is
    // written solely on the final iteration, so partial sums stay internal.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
`ifdef MULT_SIGNED_EN
        sign_d    = sign_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d  = mcand_load;
                    mplier_d = mplier_load;
                    acc_d    = '0;
                    cnt_d    = CNT_INIT;
`ifdef MULT_SIGNED_EN
                    sign_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`endif
                    state_d  = RUN;
                end
            end

            RUN: begin
                acc_d    = acc_shift;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_ONE;
                // The counter hits zero on this edge, so this is the last
                // iteration. Publish the finished accumulator directly.
                if (cnt_q == CNT_ONE) begin
                    product_d = result;
                    state_d   = DONE;
                end
            end

            DONE: begin
                // Leave DONE unconditionally. A start seen here is dropped
                // rather than queued.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset. Reset clears the
    // partial result together with the published product.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
`ifdef MULT_SIGNED_EN
            sign_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
`ifdef MULT_SIGNED_EN
            sign_q    <= sign_d;
`endif
        end
    end

    // Status outputs decode straight from the state register and are
    // therefore glitch-free.
    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_shift_add_multiplier
//
// Purpose:
//   Directed testbench for shift_add_multiplier with WIDTH=8. Each accepted
//   request pushes its hand-computed product and the cycle on which done
//   must appear into a queue. An independent monitor pops an entry whenever
//   done is seen and compares the product and the timing. A done with
//   nothing queued is flagged. Direct checks cover the reset state, busy
//   duration, product hold, and reset behaviour.
//
//   When MULT_SIGNED_EN is defined, the expected values follow
//   two's-complement semantics, and extra signed vectors are run.
// ---------------------------------------------------------------------------
module tb_shift_add_multiplier;

    localparam int WIDTH = 8;

    typedef struct {
        logic [2*WIDTH-1:0] product;
        int                 done_cyc;
        int                 id;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_compared = 0;
    int   n_failed = 0;
    int   next_id = 0;
    exp_t sb[$];

    shift_add_multiplier_if #(.WIDTH(WIDTH)) bus ();

    shift_add_multiplier #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        forever #5 clk = ~clk;
    end

    // Count rising edges so that done timing can be checked in absolute
    // cycles.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Shared comparison routine used by both the stimulus and the monitor.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Queue an expected result for a start that the DUT will sample on the
    // next rising edge. done must follow WIDTH edges later, which is seen at
    // the negedge after that edge.
    task automatic expectResult(input logic [2*WIDTH-1:0] prod, input int extra_cycles);
        exp_t e;
        e.product  = prod;
        e.done_cyc = cyc + WIDTH + 1 + extra_cycles;
        e.id       = next_id;
        next_id++;
        sb.push_back(e);
    endtask

    // Issue a single-cycle start pulse from a negedge while the DUT is idle.
    task automatic applyStimulus(input logic [WIDTH-1:0] a_in, input logic [WIDTH-1:0] b_in,
                                 input logic [2*WIDTH-1:0] prod);
        bus.start = 1'b1;
        bus.a     = a_in;
        bus.b     = b_in;
        expectResult(prod, 0);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Scoreboard monitor: consumes one expected entry per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", {31'b0, bus.done}, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput($sformatf("product[%0d]", e.id), 32'(bus.product), 32'(e.product));
                checkOutput($sformatf("done_cycle[%0d]", e.id), cyc, e.done_cyc);
            end
        end
    end

    initial begin
        int busy_cnt;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("reset_done", {31'b0, bus.done}, 32'd0);
        checkOutput("reset_product", 32'(bus.product), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 13 * 11 = 143. busy lasts exactly WIDTH cycles, and the product
        // holds after start drops.
        applyStimulus(8'd13, 8'd11, 16'h008F);
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(negedge clk);
        end
        checkOutput("busy_cycles", busy_cnt, WIDTH);
        checkOutput("product_hold", 32'(bus.product), 32'h008F);

        // Extremes: max*max and a zero operand, both taking full latency.
`ifdef MULT_SIGNED_EN
        applyStimulus(8'd255, 8'd255, 16'h0001);
`else
        applyStimulus(8'd255, 8'd255, 16'hFE01);
`endif
        repeat (10) @(negedge clk);
        applyStimulus(8'd0, 8'd200, 16'h0000);
        repeat (10) @(negedge clk);

        // Operand change after the start edge has no effect.
        applyStimulus(8'd13, 8'd11, 16'h008F);
        bus.a = 8'd100;
        repeat (10) @(negedge clk);

        // start during RUN and during DONE is ignored. start in the
        // following IDLE cycle is accepted.
        applyStimulus(8'd2, 8'd3, 16'd6);
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.a = 8'd50; bus.b = 8'd50;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.a = 8'd60; bus.b = 8'd2;
        @(negedge clk);
        bus.a = 8'd5; bus.b = 8'd7;
        expectResult(16'd35, 0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);

        // start held high re-triggers every WIDTH+2 cycles.
        bus.start = 1'b1; bus.a = 8'd3; bus.b = 8'd4;
        expectResult(16'd12, 0);
        expectResult(16'd12, WIDTH + 2);
        repeat (11) @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);

        // Reset during RUN discards the partial result.
        bus.start = 1'b1; bus.a = 8'd7; bus.b = 8'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrun_reset_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("midrun_reset_done", {31'b0, bus.done}, 32'd0);
        checkOutput("midrun_reset_product", 32'(bus.product), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        applyStimulus(8'd7, 8'd9, 16'd63);
        repeat (10) @(negedge clk);

        // Reset together with start: start is not accepted.
        reset = 1'b1; bus.start = 1'b1; bus.a = 8'd9; bus.b = 8'd9;
        @(negedge clk);
        reset = 1'b0; bus.start = 1'b0;
        checkOutput("reset_start_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("reset_start_product", 32'(bus.product), 32'd0);
        repeat (12) @(negedge clk);

`ifdef MULT_SIGNED_EN
        // Signed vectors: -3*5, -128*-128, 127*-1.
        applyStimulus(8'hFD, 8'd5, 16'hFFF1);
        repeat (10) @(negedge clk);
        applyStimulus(8'h80, 8'h80, 16'h4000);
        repeat (10) @(negedge clk);
        applyStimulus(8'h7F, 8'hFF, 16'hFF81);
        repeat (10) @(negedge clk);
`endif

        // Every queued result must have been delivered within its budget.
        repeat (5) @(negedge clk);
        checkOutput("pending_results", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential shift-and-add multiplier core for the multiplier peripheral.
- Sits directly downstream of the peripheral's operand registers, which are built from enabled D flip-flops loaded over SPI.
- Consumes the two registered operands on a start strobe and produces a registered double-width product with a done pulse.
- The product is read back through the SPI transmit path.

Parameters:
- WIDTH, 8, operand width in bits. Legal range is WIDTH >= 2. The product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on the posedge.
- reset  input  1  synchronous, active-high reset, sampled on the posedge of clk.
- start  input  1  request a multiply. Sampled only in IDLE.
- a  input  WIDTH  multiplicand, from the operand register.
- b  input  WIDTH  multiplier, from the operand register.
- busy  output  1  high while the state is RUN.
- done  output  1  one-cycle pulse when the product is valid; high only in state DONE.
- product  output  2*WIDTH  registered result; holds its value until the next completion.

Behaviour:
- Reset:
  - Synchronous; reset has priority over all other inputs.
  - state=IDLE, busy=0, done=0, product=0.
  - Internal accumulator, operand copies and counter are cleared.
- States: IDLE, RUN, DONE. All outputs are registered or decoded directly from state.
- IDLE:
  - On a posedge with start=1 (call it edge E0): latch a and b into internal copies, clear the accumulator, set the counter to WIDTH, go to RUN.
  - The a and b inputs are not sampled again after E0; changing them mid-operation has no effect.
- RUN, one iteration per clock:
  - If the multiplier copy bit0=1, the upper WIDTH+1 accumulator bits are incremented by the multiplicand copy.
  - The accumulator, including the carry, shifts right one bit.
  - The multiplier copy shifts right one bit.
  - The counter decrements.
  - When the counter reaches 0 after WIDTH iterations (edge E_WIDTH), load product from the accumulator and go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE unconditionally.
- Latency:
  - busy is high from after E0 through edge E_WIDTH.
  - done and the new product are visible after edge E_WIDTH, i.e. WIDTH clocks after the start edge.
  - Throughput is one result per WIDTH+2 cycles.
- Boundaries and simultaneous events:
  - start while in RUN or DONE is ignored and is not queued.
  - start held high continuously re-triggers on each return to IDLE.
  - Intermediate accumulator values never appear on product.
  - Arithmetic is exact and unsigned; no overflow is possible, e.g. max*max = 2^(2W) - 2^(W+1) + 1.
  - Operands of 0 still take the full WIDTH iterations; there is no early termination.
  - reset asserted mid-RUN: the next cycle is IDLE, product=0, done=0, busy=0, and the partial result is discarded.
  - reset and start asserted together: reset wins, and start is not accepted on that edge.

Optional Feature:
- Macro: MULT_SIGNED_EN.
- Defined:
  - a and b are two's-complement.
  - At E0, the magnitudes of a and b are latched as unsigned WIDTH-bit values, so the most negative value maps to 2^(WIDTH-1). The sign XOR is also latched.
  - At E_WIDTH, product is loaded with the two's-complement negation of the accumulator if the sign XOR is 1, otherwise the accumulator as-is.
  - Latency is unchanged.
- Undefined: pure unsigned operation. No sign logic is present.

Test Plan:
- WIDTH=8, a=13, b=11, start pulse at E0 -> busy high 8 cycles; done pulse after E8; product=0x008F. product stays 0x008F after start drops.
- a=255, b=255 -> product=0xFE01. a=0, b=200 -> product=0x0000, with done still exactly 8 cycles after start.
- start re-asserted during RUN and on the DONE cycle with different operands -> ignored; product reflects the first operands only. start on the following IDLE cycle is accepted.
- reset asserted at cycle 4 of RUN with a=7, b=9 -> next cycle busy=0, done=0, product=0. A subsequent start completes normally with 63.
- a changed after E0 (13 to 100) -> product still 0x008F.
- MULT_SIGNED_EN, WIDTH=8 -> a=-3, b=5 gives 0xFFF1; a=-128, b=-128 gives 0x4000; a=127, b=-1 gives 0xFF81. Latency is 8 cycles in every case.
